// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
package aes_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  typedef logic [31:0] col_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Only the coefficients used by the forward and inverse matrices are supported.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h02:   return x2;
      8'h03:   return x2 ^ b;
      8'h09:   return x8 ^ b;
      8'h0B:   return x8 ^ x2 ^ b;
      8'h0D:   return x8 ^ x4 ^ b;
      8'h0E:   return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mix_columns_engine_column.sv
// Combinational forward/inverse MixColumns on a single 32-bit column.
module mix_single_column
  import aes_pkg::*;
(
  input  col_t col_i,
  input  logic inverse,
  output col_t col_o
);

  logic [7:0] a [4];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_unpack
    assign a[gi] = col_i[31-8*gi -: 8];
  end

  // Row r uses the circulant coefficients rotated right by r.
  for (gi = 0; gi < 4; gi++) begin : g_row
    logic [7:0] fwd_byte;
    logic [7:0] inv_byte;
    assign fwd_byte = gf_mul(a[gi], 8'h02) ^ gf_mul(a[(gi+1)%4], 8'h03)
                    ^ a[(gi+2)%4] ^ a[(gi+3)%4];
    assign inv_byte = gf_mul(a[gi], 8'h0E) ^ gf_mul(a[(gi+1)%4], 8'h0B)
                    ^ gf_mul(a[(gi+2)%4], 8'h0D) ^ gf_mul(a[(gi+3)%4], 8'h09);
    assign col_o[31-8*gi -: 8] = inverse ? inv_byte : fwd_byte;
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns/InvMixColumns engine: transforms COLS_PER_CYCLE columns per cycle in place.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // For 4 columns per cycle the step truncates to 0, so one BUSY cycle finishes the state.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic         mode_q, mode_d;
  logic [127:0] work_q, work_d;

  logic         accept;
  logic [1:0]   cnt_step;
  logic [127:0] mixed_work;
  col_t         cur_col  [4];
  col_t         next_col [4];
  col_t         mixed    [COLS_PER_CYCLE];
  logic [1:0]   grp_idx  [COLS_PER_CYCLE];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_cols
    assign cur_col[gi]                 = work_q[127-32*gi -: 32];
    assign mixed_work[127-32*gi -: 32] = next_col[gi];
  end

  for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_mix
    localparam logic [1:0] OFF = 2'(gi);
    assign grp_idx[gi] = col_cnt_q + OFF;
    mix_single_column u_mix (
      .col_i   (cur_col[grp_idx[gi]]),
      .inverse (mode_q),
      .col_o   (mixed[gi])
    );
  end

  always_comb begin
    next_col = cur_col;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      next_col[grp_idx[g]] = mixed[g];
    end
  end

  assign cnt_step = col_cnt_q + STEP;

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    mode_d    = mode_q;
    work_d    = work_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: accept = in_valid;
      BUSY: begin
        work_d    = mixed_work;
        col_cnt_d = cnt_step;
        if (cnt_step == 2'd0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) accept = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      work_d    = data_in;
      mode_d    = inverse;
      col_cnt_d = 2'd0;
      state_d   = BUSY;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      mode_q    <= 1'b0;
      work_q    <= 128'h0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      mode_q    <= mode_d;
      work_q    <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) | (state_q == DONE);
  assign data_out  = work_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench driving three engines (1, 2 and 4 columns per cycle) with shared stimulus.
module tb_mix_columns_engine;

  logic         clk;
  logic         n_rst;
  logic         in_valid;
  logic         inverse;
  logic [127:0] data_in;
  logic         out_ready;

  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         busy_w      [3];
  logic [127:0] data_out_w  [3];

  int lat [3] = '{4, 2, 1};

  int n_vec = 0;
  int n_err = 0;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    mix_columns_engine #(.COLS_PER_CYCLE(1 << gi)) u_dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[gi]),
      .inverse   (inverse),
      .data_in   (data_in),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready),
      .data_out  (data_out_w[gi]),
      .busy      (busy_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] dout;
    string        tag;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int i, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cols=%0d got=%h expected=%h", name, 1 << i, act, exp);
    end
  endtask

  task automatic send(input logic inv, input logic [127:0] din);
    in_valid = 1'b1;
    inverse  = inv;
    data_in  = din;
    @(posedge clk); #1;
    // Scramble inputs after accept; the in-flight result must not change.
    in_valid = 1'b0;
    inverse  = ~inv;
    data_in  = ~din;
  endtask

  // Called #1 after the accepting edge; checks latency and result per engine.
  task automatic expect_out(input logic [127:0] exp, input string tag);
    logic exp_ov;
    for (int i = 0; i < 3; i++) begin
      chk({tag, ":ov_k0"}, i, 128'(out_valid_w[i]), 128'(0));
      chk({tag, ":busy_k0"}, i, 128'(busy_w[i]), 128'(1));
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        exp_ov = out_ready ? (k == lat[i]) : (k >= lat[i]);
        chk({tag, ":ov"}, i, 128'(out_valid_w[i]), 128'(exp_ov));
        if (exp_ov) chk({tag, ":data"}, i, data_out_w[i], exp);
      end
      $display("txn %s cycle %0d out_valid=%b%b%b", tag, k, out_valid_w[0], out_valid_w[1], out_valid_w[2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, "fwd_a"};
    vecs[1] = '{1'b1, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c, "inv_a"};
    vecs[2] = '{1'b0, {16{8'hAA}}, {16{8'hAA}}, "fwd_aa"};
    vecs[3] = '{1'b1, {16{8'hAA}}, {16{8'hAA}}, "inv_aa"};
    vecs[4] = '{1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, "inv_b"};
    vecs[5] = '{1'b0, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, "fwd_b"};

    n_rst     = 1'b0;
    in_valid  = 1'b0;
    inverse   = 1'b0;
    data_in   = 128'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst:ov", i, 128'(out_valid_w[i]), 128'(0));
      chk("rst:rdy", i, 128'(in_ready_w[i]), 128'(1));
      chk("rst:busy", i, 128'(busy_w[i]), 128'(0));
      chk("rst:data", i, data_out_w[i], 128'h0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors, back-to-back where the 1-column engine is in DONE.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 3; i++) chk({vecs[v].tag, ":rdy"}, i, 128'(in_ready_w[i]), 128'(1));
      send(vecs[v].inv, vecs[v].din);
      expect_out(vecs[v].dout, vecs[v].tag);
    end

    // Asynchronous reset while busy, then a normal transaction.
    @(posedge clk); #1;
    send(1'b0, vecs[0].din);
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst:ov", i, 128'(out_valid_w[i]), 128'(0));
      chk("midrst:rdy", i, 128'(in_ready_w[i]), 128'(1));
      chk("midrst:busy", i, 128'(busy_w[i]), 128'(0));
      chk("midrst:data", i, data_out_w[i], 128'h0);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    send(vecs[1].inv, vecs[1].din);
    expect_out(vecs[1].dout, "after_rst");

    // Backpressure: hold results, then release with a same-edge new accept.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(vecs[0].inv, vecs[0].din);
    expect_out(vecs[0].dout, "bp");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chk("bp_hold:ov", i, 128'(out_valid_w[i]), 128'(1));
        chk("bp_hold:rdy", i, 128'(in_ready_w[i]), 128'(0));
        chk("bp_hold:data", i, data_out_w[i], vecs[0].dout);
      end
      $display("txn bp_hold cycle %0d", c);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inverse   = vecs[3].inv;
    data_in   = vecs[3].din;
    #1;
    for (int i = 0; i < 3; i++) chk("b2b:rdy", i, 128'(in_ready_w[i]), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    inverse  = 1'b0;
    data_in  = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
    expect_out(vecs[3].dout, "b2b");

    // Mode latch: inputs toggle every cycle while busy.
    @(posedge clk); #1;
    in_valid = 1'b1;
    inverse  = 1'b1;
    data_in  = vecs[1].din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fork
      begin
        for (int c = 0; c < 4; c++) begin
          inverse = ~inverse;
          data_in = {data_in[63:0], data_in[127:64]} ^ 128'h5a;
          #10;
        end
      end
      expect_out(vecs[1].dout, "mode_latch");
    join

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
